// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the mem_access load/store stage.
// Contents: access size enum, stage FSM states, writeback payload struct,
// store byte-strobe and store-data lane-replication helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        COMPLETE
    } mem_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  writereg;
        logic        regwrite;
        logic        adel;
        logic        ades;
        logic [31:0] badvaddr;
    } mem_data_t;

    // Expects an address already at natural alignment for the size.
    function automatic logic [3:0] strobe_of(msize_t s, logic [1:0] a);
        return s == MSIZE_B ? 4'b0001 << a : s == MSIZE_H ? 4'b0011 << a : 4'b1111;
    endfunction

    function automatic logic [31:0] replicate(msize_t s, logic [31:0] d);
        return s == MSIZE_B ? {4{d[7:0]}} : s == MSIZE_H ? {2{d[15:0]}} : d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half out of a read word and zero/sign-extends it.
// Ports: rdata_i read word, addr_i low address bits, size_i access size,
//        signed_i sign-extend select, data_o extended load value.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  msize_t      size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata_i[{addr_i, 3'b000} +: 8];
    // Half accesses are half-aligned here, so only addr_i[1] picks the lane.
    assign h = rdata_i[{addr_i[1], 4'b0000} +: 16];

    assign data_o = size_i == MSIZE_B ? {{24{signed_i & b[7]}}, b}
                  : size_i == MSIZE_H ? {{16{signed_i & h[15]}}, h}
                  : rdata_i;

endmodule

// File: rtl/mem_access.sv
// mem_access: MIPS memory stage; issues bus loads/stores and registers the writeback payload.
// Ports: clk/reset (sync, active-high); flush kills the in-flight instruction;
//        in_* execute result with in_valid/in_ready handshake;
//        dreq_*/dresp_* data bus with valid/addr_ok/data_ok handshake;
//        out_* writeback payload with out_valid/out_ready; exc_* address errors;
//        stall to the hazard unit while a bus transaction is outstanding.
// Config: define LSU_MISALIGN_EXC_EN to raise address-error exceptions on
//         misaligned half/word accesses instead of masking the low address bits.
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_aluout,
    input  logic [ADDR_W-1:0] in_writedata,
    input  logic [REG_W-1:0]  in_writereg,
    input  logic              in_regwrite,
    output logic              dreq_valid,
    output logic              dreq_write,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_strobe,
    output logic [ADDR_W-1:0] dreq_data,
    input  logic              dreq_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [ADDR_W-1:0] dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_result,
    output logic [REG_W-1:0]  out_writereg,
    output logic              out_regwrite,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] exc_badvaddr,
    output logic              stall
);

    mem_state_t  state_q, state_d;
    logic        killed_q, killed_d;
    logic        out_valid_q, out_valid_d;
    mem_data_t   out_q, out_d;
    logic [31:0] addr_q, addr_d;
    msize_t      size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  writereg_q, writereg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strobe_q, strobe_d;
    logic [31:0] rdata_q, rdata_d;

    msize_t      size;
    logic        accept, mem_op, misaligned;
    logic [31:0] addr_m, load_data;

    assign size     = msize_t'(in_size);
    assign mem_op   = in_memread | in_memwrite;
    assign in_ready = state_q == IDLE && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign addr_m   = size == MSIZE_B ? in_aluout
                    : size == MSIZE_H ? {in_aluout[31:1], 1'b0}
                    : {in_aluout[31:2], 2'b00};

`ifdef LSU_MISALIGN_EXC_EN
    assign misaligned = size == MSIZE_B ? 1'b0 : size == MSIZE_H ? in_aluout[0] : |in_aluout[1:0];
`else
    assign misaligned = 1'b0;
`endif

    load_extend u_ext (
        .rdata_i (rdata_q),
        .addr_i  (addr_q[1:0]),
        .size_i  (size_q),
        .signed_i(signed_q),
        .data_o  (load_data)
    );

    always_comb begin
        state_d     = state_q;
        killed_d    = killed_q;
        out_valid_d = out_valid_q && !out_ready && !flush;
        out_d       = out_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        regwrite_d  = regwrite_q;
        writereg_d  = writereg_q;
        wdata_d     = wdata_q;
        strobe_d    = strobe_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: if (accept) begin
                if (!mem_op) begin
                    out_valid_d = 1'b1;
                    out_d = '{result: in_aluout, writereg: in_writereg, regwrite: in_regwrite,
                              adel: 1'b0, ades: 1'b0, badvaddr: '0};
                end else if (misaligned) begin
                    out_valid_d = 1'b1;
                    out_d = '{result: '0, writereg: in_writereg, regwrite: 1'b0,
                              adel: !in_memwrite, ades: in_memwrite, badvaddr: in_aluout};
                end else begin
                    state_d    = REQ;
                    addr_d     = addr_m;
                    size_d     = size;
                    signed_d   = in_signed;
                    write_d    = in_memwrite;
                    regwrite_d = in_regwrite;
                    writereg_d = in_writereg;
                    wdata_d    = replicate(size, in_writedata);
                    strobe_d   = in_memwrite ? strobe_of(size, addr_m[1:0]) : 4'b0000;
                end
            end
            // A flushed request still runs its bus handshake to the end; only the result is dropped.
            REQ: begin
                killed_d = killed_q | flush;
                if (dreq_addr_ok) begin
                    state_d = dresp_data_ok ? COMPLETE : WAIT;
                    rdata_d = dresp_data;
                end
            end
            WAIT: begin
                killed_d = killed_q | flush;
                if (dresp_data_ok) begin
                    state_d = COMPLETE;
                    rdata_d = dresp_data;
                end
            end
            default: begin
                state_d  = IDLE;
                killed_d = 1'b0;
                if (!killed_q && !flush) begin
                    out_valid_d = 1'b1;
                    out_d = '{result: write_q ? '0 : load_data, writereg: writereg_q,
                              regwrite: regwrite_q && !write_q, adel: 1'b0, ades: 1'b0, badvaddr: '0};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            killed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            addr_q      <= '0;
            size_q      <= MSIZE_B;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            wdata_q     <= '0;
            strobe_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            killed_q    <= killed_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            wdata_q     <= wdata_d;
            strobe_q    <= strobe_d;
            rdata_q     <= rdata_d;
        end
    end

    assign dreq_valid   = state_q == REQ;
    assign dreq_write   = write_q;
    assign dreq_addr    = {addr_q[31:2], 2'b00};
    assign dreq_strobe  = strobe_q;
    assign dreq_data    = wdata_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_q.result;
    assign out_writereg = out_q.writereg;
    assign out_regwrite = out_q.regwrite;
    assign exc_adel     = out_q.adel;
    assign exc_ades     = out_q.ades;
    assign exc_badvaddr = out_q.badvaddr;
    assign stall        = state_q != IDLE || (out_valid_q && !out_ready);

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for the mem_access memory stage.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_memread, in_memwrite, in_signed;
    logic [1:0]  in_size;
    logic [31:0] in_aluout, in_writedata, dreq_addr, dreq_data, dresp_data, out_result, exc_badvaddr;
    logic [4:0]  in_writereg, out_writereg;
    logic        in_regwrite, dreq_valid, dreq_write, dreq_addr_ok, dresp_data_ok;
    logic [3:0]  dreq_strobe;
    logic        out_valid, out_ready, out_regwrite, exc_adel, exc_ades, stall;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_memread(in_memread), .in_memwrite(in_memwrite), .in_size(in_size), .in_signed(in_signed),
        .in_aluout(in_aluout), .in_writedata(in_writedata), .in_writereg(in_writereg),
        .in_regwrite(in_regwrite), .dreq_valid(dreq_valid), .dreq_write(dreq_write),
        .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dreq_addr_ok(dreq_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_writereg(out_writereg), .out_regwrite(out_regwrite), .exc_adel(exc_adel),
        .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr), .stall(stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single cycle; the stage is expected to be ready.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wreg,
                         input logic rw);
        in_valid = 1'b1; in_memread = rd; in_memwrite = wr; in_size = sz; in_signed = sg;
        in_aluout = a; in_writedata = wd; in_writereg = wreg; in_regwrite = rw;
        tick();
        in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
        in_size = 2'd0; in_signed = 1'b0; in_aluout = '0; in_writedata = '0; in_writereg = '0;
        in_regwrite = 1'b0; dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_dreq_valid", {31'b0, dreq_valid}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // ALU op, latency 1
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
        chk("alu_valid", {31'b0, out_valid}, 32'd1);
        chk("alu_result", out_result, 32'h1234);
        chk("alu_wreg", {27'b0, out_writereg}, 32'd5);
        chk("alu_rw", {31'b0, out_regwrite}, 32'd1);
        chk("alu_stall", {31'b0, stall}, 32'd0);
        chk("alu_nobus", {31'b0, dreq_valid}, 32'd0);
        tick();
        chk("alu_drain", {31'b0, out_valid}, 32'd0);

        // LB signed at 0x80000003, addr_ok after one extra cycle, data_ok two cycles later
        issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h80000003, 32'h0, 5'd7, 1'b1);
        chk("lb_req", {31'b0, dreq_valid}, 32'd1);
        chk("lb_addr", dreq_addr, 32'h80000000);
        chk("lb_strobe", {28'b0, dreq_strobe}, 32'd0);
        chk("lb_write", {31'b0, dreq_write}, 32'd0);
        chk("lb_stall_req", {31'b0, stall}, 32'd1);
        chk("lb_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("lb_req_held", {31'b0, dreq_valid}, 32'd1);
        chk("lb_addr_held", dreq_addr, 32'h80000000);
        dreq_addr_ok = 1'b1;
        tick();
        dreq_addr_ok = 1'b0;
        chk("lb_wait_noreq", {31'b0, dreq_valid}, 32'd0);
        chk("lb_stall_wait", {31'b0, stall}, 32'd1);
        tick();
        dresp_data_ok = 1'b1; dresp_data = 32'h80FFFFFF;
        tick();
        dresp_data_ok = 1'b0; dresp_data = 32'h0;
        chk("lb_stall_cpl", {31'b0, stall}, 32'd1);
        chk("lb_cpl_nout", {31'b0, out_valid}, 32'd0);
        tick();
        chk("lb_valid", {31'b0, out_valid}, 32'd1);
        chk("lb_result", out_result, 32'hFFFFFF80);
        chk("lb_wreg", {27'b0, out_writereg}, 32'd7);
        chk("lb_stall_done", {31'b0, stall}, 32'd0);

        // SH at 0x10000002, regwrite requested but a store must not write
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h10000002, 32'h0000BEEF, 5'd9, 1'b1);
        chk("sh_strobe", {28'b0, dreq_strobe}, 32'hC);
        chk("sh_data", dreq_data, 32'hBEEFBEEF);
        chk("sh_write", {31'b0, dreq_write}, 32'd1);
        chk("sh_addr", dreq_addr, 32'h10000000);
        dreq_addr_ok = 1'b1;
        tick();
        dreq_addr_ok = 1'b0; dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        tick();
        chk("sh_valid", {31'b0, out_valid}, 32'd1);
        chk("sh_rw", {31'b0, out_regwrite}, 32'd0);

        // SB at lane 1
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h00000101, 32'h12345678, 5'd1, 1'b0);
        chk("sb_strobe", {28'b0, dreq_strobe}, 32'h2);
        chk("sb_data", dreq_data, 32'h78787878);
        dreq_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        tick();
        dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        tick();

        // LHU at 0x2, addr_ok and data_ok together: REQ -> COMPLETE
        issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h00000002, 32'h0, 5'd3, 1'b1);
        dreq_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hABCD0000;
        tick();
        dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
        chk("lhu_cpl_stall", {31'b0, stall}, 32'd1);
        chk("lhu_cpl_noreq", {31'b0, dreq_valid}, 32'd0);
        tick();
        chk("lhu_valid", {31'b0, out_valid}, 32'd1);
        chk("lhu_result", out_result, 32'h0000ABCD);
        chk("lhu_rw", {31'b0, out_regwrite}, 32'd1);

        // Flush in WAIT: bus completes, result discarded
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0, 5'd4, 1'b1);
        tick();
        chk("fl_req_held", {31'b0, dreq_valid}, 32'd1);
        dreq_addr_ok = 1'b1;
        tick();
        dreq_addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_out_clr", {31'b0, out_valid}, 32'd0);
        chk("fl_stall", {31'b0, stall}, 32'd1);
        dresp_data_ok = 1'b1; dresp_data = 32'hDEADBEEF;
        tick();
        dresp_data_ok = 1'b0;
        tick();
        chk("fl_discard", {31'b0, out_valid}, 32'd0);
        chk("fl_idle", {31'b0, stall}, 32'd0);
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h00000055, 32'h0, 5'd2, 1'b1);
        chk("fl_next_valid", {31'b0, out_valid}, 32'd1);
        chk("fl_next_result", out_result, 32'h55);

        // Flush together with in_valid: nothing accepted
        flush = 1'b1; in_valid = 1'b1; in_aluout = 32'h77;
        #1;
        chk("fv_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fv_no_out", {31'b0, out_valid}, 32'd0);

        // Misaligned LW at 0x1001
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h00001001, 32'h0, 5'd6, 1'b1);
`ifdef LSU_MISALIGN_EXC_EN
        chk("mis_noreq", {31'b0, dreq_valid}, 32'd0);
        chk("mis_valid", {31'b0, out_valid}, 32'd1);
        chk("mis_adel", {31'b0, exc_adel}, 32'd1);
        chk("mis_ades", {31'b0, exc_ades}, 32'd0);
        chk("mis_badv", exc_badvaddr, 32'h1001);
        chk("mis_rw", {31'b0, out_regwrite}, 32'd0);
        tick();
`else
        chk("mis_req", {31'b0, dreq_valid}, 32'd1);
        chk("mis_addr", dreq_addr, 32'h1000);
        dreq_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hCAFEF00D;
        tick();
        dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        tick();
        chk("mis_result", out_result, 32'hCAFEF00D);
        chk("mis_adel", {31'b0, exc_adel}, 32'd0);
`endif

        // Reset in the middle of REQ
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h00000200, 32'h0, 5'd8, 1'b1);
        chk("rr_req", {31'b0, dreq_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_noreq", {31'b0, dreq_valid}, 32'd0);
        chk("rr_stall", {31'b0, stall}, 32'd0);
        chk("rr_out", {31'b0, out_valid}, 32'd0);
        chk("rr_ready", {31'b0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
